// File: rtl/br_update_gen.sv
// br_update_gen: turns resolved branches and commit redirects into registered predictor updates.
package br_update_pkg;
   localparam int LPHT_IDX_W = 16;
   typedef struct packed {
      logic                  flush;
      logic [29:0]           br_target;
      logic [29:0]           pc;
      logic [1:0]            br_type;
      logic                  br_taken;
      logic                  btb_update;
      logic                  lpht_update;
      logic [1:0]            lphr;
      logic [LPHT_IDX_W-1:0] lphr_index;
   } bpu_update_t;
endpackage

module br_update_gen
   import br_update_pkg::*;
#(
   parameter int LPHT_ADDR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall_i,
   input  logic                       valid_i,
   input  logic                       epoch_i,
   input  logic                       is_br_i,
   input  logic [1:0]                 br_type_i,
   input  logic [29:0]                pc_i,
   input  logic                       act_taken_i,
   input  logic [29:0]                act_target_i,
   input  logic                       pred_taken_i,
   input  logic [29:0]                pred_target_i,
   input  logic [1:0]                 pred_lphr_i,
   input  logic [LPHT_ADDR_WIDTH-1:0] pred_lphr_index_i,
   input  logic                       ext_flush_i,
   input  logic [29:0]                ext_target_i,
   output bpu_update_t                update_o,
   output logic                       epoch_o,
   output logic [31:0]                br_cnt_o,
   output logic [31:0]                miss_cnt_o
);
   logic        epoch_q, accept, br_acc, mis;
   logic [1:0]  lphr_n;
   bpu_update_t nxt;

   assign epoch_o = epoch_q;

   // pc/br_type/lphr_index hold the last accepted resolution; everything else pulses
   always_comb begin
      accept = valid_i & ~stall_i & (epoch_i == epoch_q) & ~ext_flush_i;
      br_acc = accept & is_br_i;
      mis = accept & (is_br_i ? (act_taken_i != pred_taken_i) | (act_taken_i & (act_target_i != pred_target_i))
                              : pred_taken_i);
      lphr_n = act_taken_i ? (&pred_lphr_i ? 2'd3 : pred_lphr_i + 2'd1)
                           : (|pred_lphr_i ? pred_lphr_i - 2'd1 : 2'd0);
      nxt = '0;
      nxt.flush = ext_flush_i | mis;
      nxt.br_target = ext_flush_i ? ext_target_i : !mis ? 30'd0 : (is_br_i & act_taken_i) ? act_target_i : pc_i + 30'd1;
      nxt.pc = accept ? pc_i : update_o.pc;
      nxt.br_type = accept ? br_type_i : update_o.br_type;
      nxt.lphr_index = accept ? LPHT_IDX_W'(pred_lphr_index_i) : update_o.lphr_index;
      nxt.br_taken = br_acc & act_taken_i;
      nxt.btb_update = br_acc & act_taken_i & mis;
      nxt.lpht_update = br_acc & (br_type_i == 2'd0);
      nxt.lphr = nxt.lpht_update ? lphr_n : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         update_o   <= '0;
         epoch_q    <= 1'b0;
         br_cnt_o   <= '0;
         miss_cnt_o <= '0;
      end else begin
         update_o   <= nxt;
         epoch_q    <= epoch_q ^ nxt.flush;
         br_cnt_o   <= br_cnt_o + 32'(br_acc);
         miss_cnt_o <= miss_cnt_o + 32'(mis);
      end
   end
endmodule

// File: tb/tb_br_update_gen.sv
// tb_br_update_gen: directed steps with a scoreboard of hand-derived expected updates.
module tb_br_update_gen;
   import br_update_pkg::*;

   logic        clk = 0, rst = 1;
   logic        stall_i, valid_i, epoch_i, is_br_i, act_taken_i, pred_taken_i, ext_flush_i;
   logic [1:0]  br_type_i, pred_lphr_i;
   logic [29:0] pc_i, act_target_i, pred_target_i, ext_target_i;
   logic [4:0]  pred_lphr_index_i;
   bpu_update_t update_o;
   logic        epoch_o;
   logic [31:0] br_cnt_o, miss_cnt_o;

   int errors = 0, checks = 0;

   typedef struct {
      string       tag;
      logic        fl;
      logic [29:0] tgt;
      logic        btb, lpht;
      logic [1:0]  lphr;
      logic        tk;
      logic [29:0] pc;
      logic [1:0]  ty;
      logic [4:0]  idx;
      logic        ep;
      logic [31:0] bc, mc;
   } exp_t;
   exp_t sb[$];

   br_update_gen #(.LPHT_ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .valid_i(valid_i), .epoch_i(epoch_i),
      .is_br_i(is_br_i), .br_type_i(br_type_i), .pc_i(pc_i), .act_taken_i(act_taken_i),
      .act_target_i(act_target_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .pred_lphr_i(pred_lphr_i), .pred_lphr_index_i(pred_lphr_index_i),
      .ext_flush_i(ext_flush_i), .ext_target_i(ext_target_i), .update_o(update_o),
      .epoch_o(epoch_o), .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o));

   always #5 clk = ~clk;

   task automatic drive(input logic v, ep, br, input logic [1:0] ty, input logic [29:0] pc,
                        input logic pt, input logic [29:0] ptg, input logic at, input logic [29:0] atg,
                        input logic [1:0] lphr, input logic [4:0] idx,
                        input logic xf, input logic [29:0] xt, input logic st);
      valid_i = v; epoch_i = ep; is_br_i = br; br_type_i = ty; pc_i = pc;
      pred_taken_i = pt; pred_target_i = ptg; act_taken_i = at; act_target_i = atg;
      pred_lphr_i = lphr; pred_lphr_index_i = idx; ext_flush_i = xf; ext_target_i = xt; stall_i = st;
   endtask

   task automatic expect_upd(input string tag, input logic fl, input logic [29:0] tgt, input logic btb, lpht,
                             input logic [1:0] lphr, input logic tk, input logic [29:0] pc,
                             input logic [1:0] ty, input logic [4:0] idx, input logic ep,
                             input logic [31:0] bc, mc);
      sb.push_back('{tag, fl, tgt, btb, lpht, lphr, tk, pc, ty, idx, ep, bc, mc});
   endtask

   task automatic chk(input string tag, input string fld, input logic [31:0] obs, exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, "flush", 32'(update_o.flush), 32'(e.fl));
         chk(e.tag, "br_target", 32'(update_o.br_target), 32'(e.tgt));
         chk(e.tag, "btb_update", 32'(update_o.btb_update), 32'(e.btb));
         chk(e.tag, "lpht_update", 32'(update_o.lpht_update), 32'(e.lpht));
         chk(e.tag, "lphr", 32'(update_o.lphr), 32'(e.lphr));
         chk(e.tag, "br_taken", 32'(update_o.br_taken), 32'(e.tk));
         chk(e.tag, "pc", 32'(update_o.pc), 32'(e.pc));
         chk(e.tag, "br_type", 32'(update_o.br_type), 32'(e.ty));
         chk(e.tag, "lphr_index", 32'(update_o.lphr_index), 32'(e.idx));
         chk(e.tag, "epoch", 32'(epoch_o), 32'(e.ep));
         chk(e.tag, "br_cnt", br_cnt_o, e.bc);
         chk(e.tag, "miss_cnt", miss_cnt_o, e.mc);
      end
   endtask

   initial begin
      rst = 1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_upd("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 0;
      expect_upd("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 1, 0, 30'h0700_0000, 0, 30'h0, 1, 30'h0700_0010, 1, 5, 0, 0, 0);
      expect_upd("cond_mispredict", 1, 30'h0700_0010, 1, 1, 2, 1, 30'h0700_0000, 0, 5, 1, 1, 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 30'h999, 0, 30'h0, 1, 30'h888, 1, 3, 0, 0, 0);
         expect_upd("wrong_path", 0, 0, 0, 0, 0, 0, 30'h0700_0000, 0, 5, 1, 1, 1);
         tick();
      end
      drive(1, 1, 1, 0, 30'h100, 0, 30'h0, 0, 30'h0, 0, 6, 0, 0, 0);
      expect_upd("nt_correct_sat0", 0, 0, 0, 1, 0, 0, 30'h100, 0, 6, 1, 2, 1);
      tick();
      drive(1, 1, 1, 0, 30'h200, 1, 30'h210, 1, 30'h210, 3, 7, 0, 0, 0);
      expect_upd("tk_correct_sat3", 0, 0, 0, 1, 3, 1, 30'h200, 0, 7, 1, 3, 1);
      tick();
      drive(1, 1, 1, 1, 30'h300, 1, 30'h300, 1, 30'h304, 2, 8, 0, 0, 0);
      expect_upd("call_bad_target", 1, 30'h304, 1, 0, 0, 1, 30'h300, 1, 8, 0, 4, 2);
      tick();
      drive(1, 0, 0, 0, 30'h3FFF_FFFF, 1, 30'h5, 0, 30'h0, 0, 9, 0, 0, 0);
      expect_upd("nonbr_wrap", 1, 30'h0, 0, 0, 0, 0, 30'h3FFF_FFFF, 0, 9, 1, 4, 3);
      tick();
      drive(1, 1, 1, 0, 30'h500, 0, 30'h0, 1, 30'h520, 1, 11, 0, 0, 1);
      expect_upd("stalled", 0, 0, 0, 0, 0, 0, 30'h3FFF_FFFF, 0, 9, 1, 4, 3);
      tick();
      drive(1, 1, 1, 0, 30'h400, 1, 30'h480, 0, 30'h0, 2, 10, 0, 0, 0);
      expect_upd("pred_tk_act_nt", 1, 30'h401, 0, 1, 1, 0, 30'h400, 0, 10, 0, 5, 4);
      tick();
      drive(1, 0, 1, 0, 30'h600, 0, 30'h0, 1, 30'h640, 1, 12, 1, 30'h0700_0400, 0);
      expect_upd("ext_over_branch", 1, 30'h0700_0400, 0, 0, 0, 0, 30'h400, 0, 10, 1, 5, 4);
      tick();
      drive(0, 0, 0, 0, 30'h0, 0, 30'h0, 0, 30'h0, 0, 0, 1, 30'h123, 1);
      expect_upd("ext_during_stall", 1, 30'h123, 0, 0, 0, 0, 30'h400, 0, 10, 0, 5, 4);
      tick();
      rst = 1;
      drive(1, 0, 1, 0, 30'h700, 0, 30'h0, 1, 30'h740, 1, 13, 0, 0, 0);
      expect_upd("reset_vs_mispredict", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_upd("idle_after_reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
